// File: rtl/stopwatch_ctrl_if.sv
// Button levels in, counter/display controls out, between the stopwatch
// button front end and the time counters.
interface stopwatch_ctrl_if;
  logic STRTSTOP;
  logic LAP;
  logic CLK_EN;
  logic RUNNING;
  logic LAP_HOLD;
  logic CNT_CLR;

  modport master (
    output STRTSTOP,
    output LAP,
    input  CLK_EN,
    input  RUNNING,
    input  LAP_HOLD,
    input  CNT_CLR
  );

  modport slave (
    input  STRTSTOP,
    input  LAP,
    output CLK_EN,
    output RUNNING,
    output LAP_HOLD,
    output CNT_CLR
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detect with lockout, start/stop/lap/clear FSM
// and the tenths prescaler that gates the time counters.
module stopwatch_ctrl #(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned LOCKOUT = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  stopwatch_ctrl_if.slave  sw
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT + 1);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_RUN,
    ST_LAP,
    ST_STOP
  } state_e;

  state_e            state_q, state_d;
  logic              ss_s1_q, ss_s2_q;
  logic              lap_s1_q, lap_s2_q;
  logic [LOCK_W-1:0] lock_q, lock_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              clk_en_q, clk_en_d;
  logic              running_q, running_d;
  logic              lap_hold_q, lap_hold_d;
  logic              cnt_clr_q, cnt_clr_d;

  logic              ss_edge, lap_edge;
  logic              counting;

  // Next state, lockout, prescaler and output decode
  always_comb begin
    state_d    = state_q;
    lock_d     = lock_q;
    div_d      = div_q;
    clk_en_d   = 1'b0;
    running_d  = 1'b0;
    lap_hold_d = 1'b0;
    cnt_clr_d  = 1'b0;

    ss_edge  = ss_s1_q  & ~ss_s2_q  & (lock_q == '0);
    lap_edge = lap_s1_q & ~lap_s2_q & (lock_q == '0);
    counting = (state_q == ST_RUN) || (state_q == ST_LAP);

    // Any accepted edge rearms the lockout, even if the FSM ignores it
    if (ss_edge || lap_edge) begin
      lock_d = LOCK_LOAD;
    end else if (lock_q != '0) begin
      lock_d = lock_q - LOCK_W'(1);
    end

    if (state_q == ST_CLEAR) begin
      div_d = '0;
    end else if (counting) begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + DIV_W'(1);
    end

    case (state_q)
      ST_CLEAR: state_d = ST_IDLE;
      ST_IDLE:  if (ss_edge) state_d = ST_RUN;
      ST_RUN: begin
        if (ss_edge)       state_d = ST_STOP;
        else if (lap_edge) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ss_edge)       state_d = ST_STOP;
        else if (lap_edge) state_d = ST_RUN;
      end
      ST_STOP: begin
        if (ss_edge)       state_d = ST_RUN;
        else if (lap_edge) state_d = ST_CLEAR;
      end
      default: state_d = ST_CLEAR;
    endcase

    // Outputs registered from next-state values: same cycle as a direct state decode
    running_d  = (state_d == ST_RUN) || (state_d == ST_LAP);
    lap_hold_d = (state_d == ST_LAP);
    cnt_clr_d  = (state_d == ST_CLEAR);
    clk_en_d   = running_d && (div_d == DIV_MAX);
  end

  // Synchronous active-low reset; synchronisers reset high so a held button gives no edge
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= ST_CLEAR;
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      lap_s1_q   <= 1'b1;
      lap_s2_q   <= 1'b1;
      lock_q     <= '0;
      div_q      <= '0;
      clk_en_q   <= 1'b0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
      cnt_clr_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      ss_s1_q    <= sw.STRTSTOP;
      ss_s2_q    <= ss_s1_q;
      lap_s1_q   <= sw.LAP;
      lap_s2_q   <= lap_s1_q;
      lock_q     <= lock_d;
      div_q      <= div_d;
      clk_en_q   <= clk_en_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
      cnt_clr_q  <= cnt_clr_d;
    end
  end

  assign sw.CLK_EN   = clk_en_q;
  assign sw.RUNNING  = running_q;
  assign sw.LAP_HOLD = lap_hold_q;
  assign sw.CNT_CLR  = cnt_clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: per-cycle vector table plus a tick-count sequence.
module tb_stopwatch_ctrl;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned LOCKOUT = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(
    .CLK_DIV (CLK_DIV),
    .LOCKOUT (LOCKOUT)
  ) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .sw      (sw_if)
  );

  // exp = {CLK_EN, RUNNING, LAP_HOLD, CNT_CLR} after each posedge
  typedef struct {
    int         n;
    logic       rst_n;
    logic       ss;
    logic       lap;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic add(input int n, input logic r, input logic s, input logic l,
                     input logic [3:0] e, input string nm);
    vec_t v;
    v.n = n; v.rst_n = r; v.ss = s; v.lap = l; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic s, input logic l);
    @(negedge clk);
    rst_n = r;
    sw_if.STRTSTOP = s;
    sw_if.LAP = l;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] outs();
    return {sw_if.CLK_EN, sw_if.RUNNING, sw_if.LAP_HOLD, sw_if.CNT_CLR};
  endfunction

  task automatic check_vec(input string nm, input logic [3:0] got, input logic [3:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (clk_en,running,lap_hold,cnt_clr)", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        step(vecs[i].rst_n, vecs[i].ss, vecs[i].lap);
        check_vec($sformatf("%s[%0d]", vecs[i].name, k), outs(), vecs[i].exp);
      end
    end
  endtask

  initial begin
    int split;
    int first_tick;
    int ticks;
    int run_ok;

    rst_n = 1'b0;
    sw_if.STRTSTOP = 1'b1;
    sw_if.LAP = 1'b0;

    // Reset with button held, then idle and first sample of a start press
    add( 3, 0, 1, 0, 4'b0001, "t1_reset");
    add(10, 1, 1, 0, 4'b0000, "t1_held_btn");
    add( 2, 1, 0, 0, 4'b0000, "t2_idle");
    add( 1, 1, 1, 0, 4'b0000, "t2_first_sample");
    split = vecs.size();
    // Pause mid-period and resume
    add( 1, 1, 0, 0, 4'b0100, "t3_run_div0");
    add( 1, 1, 1, 0, 4'b0100, "t3_run_div1");
    add( 1, 1, 1, 0, 4'b0000, "t3_stop");
    add(20, 1, 0, 0, 4'b0000, "t3_stopped");
    add( 1, 1, 1, 0, 4'b0000, "t3_restart_sample");
    add( 1, 1, 1, 0, 4'b0100, "t3_rerun");
    add( 1, 1, 0, 0, 4'b1100, "t3_first_tick");
    // Lockout: edge 5 cycles after previous is lost, 9 cycles apart both accepted
    add( 2, 1, 0, 0, 4'b0100, "t4_run");
    add( 1, 1, 1, 0, 4'b0100, "t4_edge2_sample");
    add( 1, 1, 1, 0, 4'b1100, "t4_edge2_ignored");
    add( 3, 1, 1, 0, 4'b0100, "t4_still_run");
    add( 1, 1, 0, 0, 4'b1100, "t4_tick");
    add( 1, 1, 0, 0, 4'b0100, "t4_run2");
    add( 1, 1, 1, 0, 4'b0100, "t4_edgeA_sample");
    add( 1, 1, 1, 0, 4'b0000, "t4_edgeA_stop");
    add( 7, 1, 0, 0, 4'b0000, "t4_stopped");
    add( 1, 1, 1, 0, 4'b0000, "t4_edgeB_sample");
    add( 1, 1, 1, 0, 4'b0100, "t4_edgeB_run");
    // Lap keeps ticking; simultaneous press resolves to stop
    add( 1, 1, 0, 0, 4'b1100, "t5_tick");
    add( 3, 1, 0, 0, 4'b0100, "t5_run");
    add( 1, 1, 0, 0, 4'b1100, "t5_tick2");
    add( 2, 1, 0, 0, 4'b0100, "t5_run2");
    add( 1, 1, 0, 1, 4'b0100, "t5_lap_sample");
    add( 1, 1, 0, 1, 4'b1110, "t5_lap_tick");
    add( 3, 1, 0, 0, 4'b0110, "t5_lap");
    add( 1, 1, 0, 0, 4'b1110, "t5_lap_tick2");
    add( 3, 1, 0, 0, 4'b0110, "t5_lap2");
    add( 1, 1, 0, 0, 4'b1110, "t5_lap_tick3");
    add( 1, 1, 0, 0, 4'b0110, "t5_lap3");
    add( 1, 1, 1, 1, 4'b0110, "t5_both_sample");
    add( 1, 1, 1, 1, 4'b0000, "t5_both_stop");
    // Clear from stop (div was 2), restart from zero, then reset mid-run
    add( 7, 1, 0, 0, 4'b0000, "t6_stopped");
    add( 1, 1, 0, 1, 4'b0000, "t6_lap_sample");
    add( 1, 1, 0, 1, 4'b0001, "t6_clear");
    add( 1, 1, 0, 1, 4'b0000, "t6_idle");
    add( 7, 1, 0, 0, 4'b0000, "t6_idle_wait");
    add( 1, 1, 1, 0, 4'b0000, "t6_start_sample");
    add( 1, 1, 1, 0, 4'b0100, "t6_run_div0");
    add( 2, 1, 0, 0, 4'b0100, "t6_run_from_zero");
    add( 1, 0, 0, 0, 4'b0001, "t6_reset_midrun");
    add( 1, 1, 0, 0, 4'b0000, "t6_post_reset");
    add( 1, 1, 1, 0, 4'b0000, "t6_lock_clear_sample");
    add( 1, 1, 1, 0, 4'b0100, "t6_lock_clear_run");

    run_rows(0, split);

    // 40 cycles from RUN entry: ticks on every 4th cycle, first on the 4th
    first_tick = -1;
    ticks = 0;
    run_ok = 1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, logic'(i < 3), 1'b0);
      if (sw_if.CLK_EN === 1'b1) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
      if (sw_if.RUNNING !== 1'b1) run_ok = 0;
    end
    check_int("t2_first_tick_cycle", first_tick, 3);
    check_int("t2_tick_count", ticks, 10);
    check_int("t2_running_held", run_ok, 1);

    run_rows(split, vecs.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
